// File: rtl/slide.sv
// Slide/duck vertical motion for the runner sprite; outputs are registered and change one clk after a qualifying tick.
// No backpressure: motion advances only on tick. Define SLIDE_CANCEL_EN to let 'up' abort DUCK/HOLD straight into RISE.
module slide #(
    parameter int WIDTH      = 12,
    parameter int GROUND_TOP = 40,
    parameter int SLIDE_TOP  = 70,
    parameter int FULL_H     = 60,
    parameter int STEP       = 10,
    parameter int HOLD_TICKS = 30,
    parameter int COOL_TICKS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             down,
    input  logic             airborne,
    input  logic             up,
    output logic [WIDTH-1:0] top_y,
    output logic [WIDTH-1:0] height,
    output logic             sliding,
    output logic             busy
);

    localparam int MAXT = (HOLD_TICKS > COOL_TICKS) ? HOLD_TICKS : COOL_TICKS;
    localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;

    localparam logic [WIDTH:0]   C_STEP   = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   C_SLIDE  = (WIDTH+1)'(SLIDE_TOP);
    localparam logic [WIDTH:0]   C_GROUND = (WIDTH+1)'(GROUND_TOP);
    localparam logic [WIDTH-1:0] Y_GROUND = WIDTH'(GROUND_TOP);
    localparam logic [WIDTH-1:0] Y_SLIDE  = WIDTH'(SLIDE_TOP);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DUCK = 3'd1,
        S_HOLD = 3'd2,
        S_RISE = 3'd3,
        S_COOL = 3'd4
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_top_y;
    logic [WIDTH-1:0] r_height;
    logic             r_sliding;
    logic             r_busy;

    logic [WIDTH:0]   w_duck_sum;
    logic [WIDTH-1:0] w_duck_y;
    logic [WIDTH-1:0] w_rise_y;
    logic             w_cancel;

`ifdef SLIDE_CANCEL_EN
    assign w_cancel = up;
`else
    logic w_unused_up;
    assign w_unused_up = up;
    assign w_cancel    = 1'b0;
`endif

    // One extra bit so a large STEP near the top of the range saturates instead of wrapping.
    assign w_duck_sum = {1'b0, r_top_y} + C_STEP;
    assign w_duck_y   = (w_duck_sum >= C_SLIDE) ? Y_SLIDE : w_duck_sum[WIDTH-1:0];
    assign w_rise_y   = ({1'b0, r_top_y} < (C_GROUND + C_STEP)) ? Y_GROUND
                                                                 : (r_top_y - WIDTH'(STEP));

    function automatic logic [WIDTH-1:0] f_height(input logic [WIDTH-1:0] y);
        return WIDTH'(FULL_H) - (y - Y_GROUND);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_top_y   <= Y_GROUND;
            r_height  <= WIDTH'(FULL_H);
            r_sliding <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (tick && down && !airborne) begin
                        r_state   <= S_DUCK;
                        r_sliding <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_DUCK: begin
                    if (tick) begin
                        if (w_cancel) begin
                            r_state <= S_RISE;
                        end else begin
                            r_top_y  <= w_duck_y;
                            r_height <= f_height(w_duck_y);
                            if (w_duck_y == Y_SLIDE) begin
                                r_state <= S_HOLD;
                                r_cnt   <= CW'(HOLD_TICKS - 1);
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (tick) begin
                        if (w_cancel || r_cnt == '0) begin
                            r_state <= S_RISE;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                end
                S_RISE: begin
                    if (tick) begin
                        r_top_y  <= w_rise_y;
                        r_height <= f_height(w_rise_y);
                        if (w_rise_y == Y_GROUND) begin
                            r_sliding <= 1'b0;
                            if (COOL_TICKS == 0) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= S_COOL;
                                r_cnt   <= CW'(COOL_TICKS - 1);
                            end
                        end
                    end
                end
                S_COOL: begin
                    if (tick) begin
                        if (r_cnt == '0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cnt     <= '0;
                    r_top_y   <= Y_GROUND;
                    r_height  <= WIDTH'(FULL_H);
                    r_sliding <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign top_y   = r_top_y;
    assign height  = r_height;
    assign sliding = r_sliding;
    assign busy    = r_busy;

endmodule

// File: tb/tb_slide.sv
// Bench for slide: vector table, hand-written corner sequences, then random stimulus against a schedule model.
module tb_slide;

    localparam int GT   = 40;
    localparam int ST   = 70;
    localparam int FH   = 60;
    localparam int STEP = 10;
    localparam int HOLD = 30;
    localparam int COOL = 8;
`ifdef SLIDE_CANCEL_EN
    localparam bit CANCEL = 1'b1;
`else
    localparam bit CANCEL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        down = 1'b0;
    logic        airborne = 1'b0;
    logic        up = 1'b0;
    logic [11:0] top_y, height, s_top_y, s_height;
    logic        sliding, busy, s_sliding, s_busy;

    always #5 clk = ~clk;

    slide u_dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .down(down), .airborne(airborne), .up(up),
        .top_y(top_y), .height(height), .sliding(sliding), .busy(busy)
    );

    slide #(.STEP(25)) u_sat (
        .clk(clk), .rst_n(rst_n), .tick(tick), .down(down), .airborne(airborne), .up(up),
        .top_y(s_top_y), .height(s_height), .sliding(s_sliding), .busy(s_busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic cyc(input bit r, input bit t, input bit d, input bit a, input bit u);
        rst_n = r; tick = t; down = d; airborne = a; up = u;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all(input string nm, input int y, input bit sl, input bit bz);
        chk({nm, ".top_y"}, 32'(top_y), 32'(y));
        chk({nm, ".height"}, 32'(height), 32'(FH - (y - GT)));
        chk({nm, ".sliding"}, 32'(sliding), 32'(sl));
        chk({nm, ".busy"}, 32'(busy), 32'(bz));
    endtask

    // Reference model: a slide start pre-computes its whole per-tick schedule of outputs.
    typedef struct { int y; bit sl; bit bz; bit cn; } ent_t;
    ent_t m_cur;
    ent_t m_q[$];

    function automatic void m_push(input int y, input bit sl, input bit bz, input bit cn);
        m_q.push_back('{y, sl, bz, cn});
    endfunction

    function automatic void m_tail(input int y);
        int v = y;
        bit done = 1'b0;
        while (!done) begin
            v = (v - STEP < GT) ? GT : v - STEP;
            if (v == GT) begin
                m_push(v, 1'b0, COOL != 0, 1'b0);
                done = 1'b1;
            end else begin
                m_push(v, 1'b1, 1'b1, 1'b0);
            end
        end
        for (int i = 1; i < COOL; i++) m_push(GT, 1'b0, 1'b1, 1'b0);
        if (COOL > 0) m_push(GT, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic void m_start();
        int v = GT;
        m_cur = '{GT, 1'b1, 1'b1, 1'b1};
        while (v != ST) begin
            v = (v + STEP > ST) ? ST : v + STEP;
            m_push(v, 1'b1, 1'b1, 1'b1);
        end
        for (int i = 1; i < HOLD; i++) m_push(ST, 1'b1, 1'b1, 1'b1);
        m_push(ST, 1'b1, 1'b1, 1'b0);
        m_tail(ST);
    endfunction

    function automatic void m_step(input bit r, input bit t, input bit d, input bit a, input bit u);
        if (!r) begin
            m_q.delete();
            m_cur = '{GT, 1'b0, 1'b0, 1'b0};
        end else if (t) begin
            if (CANCEL && u && m_cur.cn) begin
                m_q.delete();
                m_cur = '{m_cur.y, 1'b1, 1'b1, 1'b0};
                m_tail(m_cur.y);
            end else if (m_q.size() > 0) begin
                m_cur = m_q.pop_front();
            end else if (d && !a) begin
                m_start();
            end
        end
    endfunction

    typedef struct { bit r; bit t; bit d; bit a; int y; bit sl; bit bz; } vec_t;
    vec_t vt[13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int  ey, sy;
        bit  esl, ebz, ssl;
        bit  r, t, d, a, u;
        int  guard;

        // {rst_n, tick, down, airborne, exp top_y, exp sliding, exp busy}
        vt[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 40, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 40, 1'b0, 1'b0};
        for (int i = 2; i <= 6; i++) vt[i] = '{1'b1, 1'b1, 1'b1, 1'b1, 40, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 40, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 40, 1'b1, 1'b1};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 40, 1'b1, 1'b1};
        vt[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 50, 1'b1, 1'b1};
        vt[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 40, 1'b0, 1'b0};
        vt[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 40, 1'b0, 1'b0};

        for (int i = 0; i < 13; i++) begin
            cyc(vt[i].r, vt[i].t, vt[i].d, vt[i].a, 1'b0);
            chk_all($sformatf("vec%0d", i), vt[i].y, vt[i].sl, vt[i].bz);
        end

        // Full slide with down held throughout: hold length, cooldown, and restart timing.
        cyc(1, 1, 1, 0, 0);
        chk_all("start", GT, 1'b1, 1'b1);
        for (int k = 1; k <= 45; k++) begin
            if (k % 4 == 0) cyc(1, 0, 1, 0, 0);
            cyc(1, 1, 1, 0, 0);
            if (k <= 3)       ey = GT + STEP * k;
            else if (k <= 33) ey = ST;
            else if (k <= 36) ey = ST - STEP * (k - 33);
            else              ey = GT;
            esl = (k <= 35) || (k == 45);
            ebz = (k <= 43) || (k == 45);
            chk_all($sformatf("slide.t%0d", k), ey, esl, ebz);
            if (k <= 34) begin
                if (k == 1)       sy = 65;
                else if (k <= 32) sy = ST;
                else if (k == 33) sy = 45;
                else              sy = GT;
                ssl = (k <= 33);
                chk($sformatf("sat.t%0d.top_y", k), 32'(s_top_y), 32'(sy));
                chk($sformatf("sat.t%0d.height", k), 32'(s_height), 32'(FH - (sy - GT)));
                chk($sformatf("sat.t%0d.sliding", k), 32'(s_sliding), 32'(ssl));
            end
        end

        // Reset in the middle of HOLD.
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0);
        for (int k = 0; k < 13; k++) cyc(1, 1, 0, 0, 0);
        chk_all("midhold", ST, 1'b1, 1'b1);
        cyc(0, 1, 1, 0, 0);
        chk_all("rst_midhold", GT, 1'b0, 1'b0);
        cyc(1, 1, 0, 0, 0);
        chk_all("after_rst", GT, 1'b0, 1'b0);

        // Cancel request on the fifth HOLD tick.
        cyc(1, 1, 1, 0, 0);
        for (int k = 0; k < 7; k++) cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 1);
        chk_all("cancel_tick", ST, 1'b1, 1'b1);
        cyc(1, 1, 0, 0, 0);
        chk_all("cancel_next", CANCEL ? ST - STEP : ST, 1'b1, 1'b1);
        guard = 0;
        while (busy && guard < 200) begin
            cyc(1, 1, 0, 0, 0);
            guard++;
        end
        chk("drain.busy", 32'(busy), 32'd0);
        chk("drain.top_y", 32'(top_y), 32'(GT));

        // Random stimulus against the schedule model.
        cyc(0, 1, 0, 0, 0);
        m_step(0, 1, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(399) != 0);
            t = ($urandom_range(2) != 0);
            d = ($urandom_range(3) != 0);
            a = ($urandom_range(4) == 0);
            u = ($urandom_range(15) == 0);
            cyc(r, t, d, a, u);
            m_step(r, t, d, a, u);
            chk_all($sformatf("rnd%0d", n), m_cur.y, m_cur.sl, m_cur.bz);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/slide.md
Name: slide

Overview:
- Vertical "slide/duck" motion controller for the runner sprite; the downward counterpart to the jump controller.
- On a frame tick with the down request asserted, it drops the sprite's top edge toward the floor, holds the crouch for a fixed number of frames, then rises back to standing.
- Outputs sprite top-y and live sprite height to the renderer and collision logic.
- Sits beside the jump block in the player-motion path. Player-motion mux selects slide outputs while `sliding`=1.

Parameters:
- WIDTH, 12: width of all position/height values.
- GROUND_TOP, 40: top-y of the standing sprite. Screen y grows downward.
- SLIDE_TOP, 70: top-y at full crouch. Must be > GROUND_TOP.
- FULL_H, 60: standing sprite height in pixels. Must be > SLIDE_TOP-GROUND_TOP.
- STEP, 10: pixels moved per tick while ducking/rising. Must be ≥1.
- HOLD_TICKS, 30: ticks spent fully crouched. Must be ≥1.
- COOL_TICKS, 8: ticks after standing during which new slides are refused.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: synchronous active-low reset, sampled on posedge clk.
- tick, input, 1: one-cycle frame strobe. All motion advances only on tick.
- down, input, 1: slide request, level, sampled on tick.
- airborne, input, 1: jump block is mid-jump. Slide starts are blocked while high.
- up, input, 1: cancel request. Used only when SLIDE_CANCEL_EN is defined, otherwise ignored.
- top_y, output, WIDTH: registered sprite top-y.
- height, output, WIDTH: registered sprite height, always FULL_H-(top_y-GROUND_TOP).
- sliding, output, 1: high in DUCK, HOLD, RISE.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, top_y=GROUND_TOP, height=FULL_H.
  - sliding=0, busy=0, counter=0.
  - Reset wins over tick in the same cycle and aborts any slide immediately.
- Non-tick cycles: all registers hold.
- Outputs are registered. Every change appears the cycle after the qualifying tick.
- IDLE:
  - top_y=GROUND_TOP.
  - On tick with down=1 and airborne=0, go to DUCK. top_y does not move on this tick.
  - down=1 with airborne=1 is dropped and not queued.
- DUCK:
  - Each tick: top_y=min(top_y+STEP, SLIDE_TOP). Compute in WIDTH+1 bits so there is no wrap.
  - On the tick where the new value equals SLIDE_TOP, go to HOLD and load counter=HOLD_TICKS-1.
  - With defaults: 40→50→60→70, 3 ticks.
- HOLD:
  - top_y=SLIDE_TOP.
  - Each tick: if counter==0, go to RISE; else counter-=1.
  - Exactly HOLD_TICKS ticks are spent in HOLD.
  - down is ignored; holding it does not extend the crouch.
- RISE:
  - Each tick: top_y=max(top_y-STEP, GROUND_TOP). Saturating, no underflow.
  - On reaching GROUND_TOP, go to COOL and load counter=COOL_TICKS-1.
  - If COOL_TICKS=0, go straight to IDLE.
- COOL:
  - top_y=GROUND_TOP, sliding=0, busy=1.
  - down is ignored.
  - Each tick: if counter==0, go to IDLE; else counter-=1.
- airborne rising mid-slide has no effect; the slide completes. Mutual exclusion is the jump block's job via busy.
- height is registered alongside top_y and is never combinationally derived from the output.
- Illegal or unused state encodings go to IDLE with top_y=GROUND_TOP on the next clk.

Optional Feature:
- Macro: SLIDE_CANCEL_EN.
- Defined: a tick with up=1 while in DUCK or HOLD goes straight to RISE. top_y does not move on that tick. The HOLD counter is discarded.
- Not defined: the up port is unused, and a slide always runs its full DUCK/HOLD/RISE/COOL sequence.

Test Plan:
- Reset: rst_n=0 for 2 clks with tick toggling → top_y=40, height=60, sliding=0, busy=0, no movement.
- Basic slide, defaults:
  - down=1 on one tick → DUCK.
  - Next 3 ticks → top_y 50, 60, 70; height 50, 40, 30.
  - 30 ticks held at 70.
  - 3 ticks → 60, 50, 40.
  - 8 COOL ticks with busy=1, then IDLE.
  - sliding high from the start tick until top_y returns to 40.
- Blocking: down=1 with airborne=1 for 5 ticks → top_y stays 40, busy=0. Drop airborne with down=1 → slide starts on that tick.
- Cooldown and hold: down held continuously → HOLD lasts exactly 30 ticks. The next slide starts on the first IDLE tick after 8 COOL ticks, not earlier.
- Saturation: STEP=25 → DUCK 40→65→70, RISE 70→45→40. No overshoot or wrap.
- Reset mid-HOLD → next cycle top_y=40, state IDLE.
  - With SLIDE_CANCEL_EN: up=1 at HOLD tick 5 → RISE begins; top_y=60 on the following tick.
  - Without the macro: the same up has no effect.
